// File: rtl/accel_spi_reader.sv
// SPI mode-3 master: writes one accelerometer control register after reset, then
// reads the X and Y high bytes on each accepted sample tick and publishes them together.
module accel_spi_reader #(
  parameter int unsigned CLK_DIV       = 18,
  parameter int unsigned SAMPLE_PERIOD = 36000,
  parameter logic [7:0]  INIT_ADDR     = 8'h20,
  parameter logic [7:0]  INIT_DATA     = 8'h77,
  parameter logic [7:0]  X_ADDR        = 8'h29,
  parameter logic [7:0]  Y_ADDR        = 8'h2B
) (
  input  logic       pixel_clk,
  input  logic       rst,
  output logic       spi_sclk,
  output logic       spi_cs_n,
  output logic       spi_mosi,
  input  logic       spi_miso,
  output logic [7:0] accel_data_x,
  output logic [7:0] accel_data_y,
  output logic       data_valid,
  output logic       init_done
);

  localparam int unsigned SMP_W  = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int unsigned DIV_W  = $clog2(CLK_DIV);
  localparam int unsigned HOLD_W = $clog2(2 * CLK_DIV);
  localparam int unsigned HALF_W = 6;

  localparam logic [SMP_W-1:0]  SMP_LAST  = SMP_W'(SAMPLE_PERIOD - 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(2 * CLK_DIV - 1);
  localparam logic [HALF_W-1:0] HALF_END  = HALF_W'(32);

  localparam logic [15:0] INIT_WORD = {INIT_ADDR & 8'h7F, INIT_DATA};
  localparam logic [15:0] X_WORD    = {8'h80 | X_ADDR, 8'h00};
  localparam logic [15:0] Y_WORD    = {8'h80 | Y_ADDR, 8'h00};

  localparam logic [2:0] S_INIT_XFER = 3'd0;
  localparam logic [2:0] S_WAIT      = 3'd1;
  localparam logic [2:0] S_READ_X    = 3'd2;
  localparam logic [2:0] S_GAP       = 3'd3;
  localparam logic [2:0] S_READ_Y    = 3'd4;
  localparam logic [2:0] S_UPDATE    = 3'd5;

  logic [2:0]        state,    state_d;
  logic [SMP_W-1:0]  smp_cnt,  smp_cnt_d;
  logic [DIV_W-1:0]  div_cnt,  div_cnt_d;
  logic [HALF_W-1:0] half_cnt, half_cnt_d;
  logic [HOLD_W-1:0] hold_cnt, hold_cnt_d;
  logic [15:0]       tx_sr,    tx_sr_d;
  logic [7:0]        rx_sr,    rx_sr_d;
  logic [7:0]        x_hold,   x_hold_d;
  logic              spi_sclk_d, spi_cs_n_d, spi_mosi_d;
  logic [7:0]        accel_data_x_d, accel_data_y_d;
  logic              data_valid_d, init_done_d;

  logic              tick_c, done_c, gap_ok_c, start_c;
  logic [15:0]       word_c;

  assign tick_c   = (smp_cnt == SMP_LAST);
  assign done_c   = !spi_cs_n && (div_cnt == DIV_LAST) && (half_cnt == HALF_END);
  // CS has been high for at least 2*CLK_DIV cycles once this saturates
  assign gap_ok_c = (hold_cnt == HOLD_LAST);

  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      state        <= S_INIT_XFER;
      smp_cnt      <= '0;
      div_cnt      <= '0;
      half_cnt     <= '0;
      hold_cnt     <= '0;
      tx_sr        <= '0;
      rx_sr        <= '0;
      x_hold       <= '0;
      spi_sclk     <= 1'b1;
      spi_cs_n     <= 1'b1;
      spi_mosi     <= 1'b0;
      accel_data_x <= '0;
      accel_data_y <= '0;
      data_valid   <= 1'b0;
      init_done    <= 1'b0;
    end else begin
      state        <= state_d;
      smp_cnt      <= smp_cnt_d;
      div_cnt      <= div_cnt_d;
      half_cnt     <= half_cnt_d;
      hold_cnt     <= hold_cnt_d;
      tx_sr        <= tx_sr_d;
      rx_sr        <= rx_sr_d;
      x_hold       <= x_hold_d;
      spi_sclk     <= spi_sclk_d;
      spi_cs_n     <= spi_cs_n_d;
      spi_mosi     <= spi_mosi_d;
      accel_data_x <= accel_data_x_d;
      accel_data_y <= accel_data_y_d;
      data_valid   <= data_valid_d;
      init_done    <= init_done_d;
    end
  end

  always_comb begin
    state_d        = state;
    smp_cnt_d      = tick_c ? '0 : smp_cnt + SMP_W'(1);
    div_cnt_d      = div_cnt;
    half_cnt_d     = half_cnt;
    hold_cnt_d     = spi_cs_n ? (gap_ok_c ? hold_cnt : hold_cnt + HOLD_W'(1)) : '0;
    tx_sr_d        = tx_sr;
    rx_sr_d        = rx_sr;
    x_hold_d       = x_hold;
    spi_sclk_d     = spi_sclk;
    spi_cs_n_d     = spi_cs_n;
    spi_mosi_d     = spi_mosi;
    accel_data_x_d = accel_data_x;
    accel_data_y_d = accel_data_y;
    data_valid_d   = 1'b0;
    init_done_d    = init_done;
    start_c        = 1'b0;
    word_c         = INIT_WORD;

    // Bit engine: even half-periods end in a fall (MOSI shift), odd ones in a rise (MISO sample)
    if (!spi_cs_n) begin
      if (div_cnt == DIV_LAST) begin
        div_cnt_d  = '0;
        half_cnt_d = half_cnt + HALF_W'(1);
        if (half_cnt == HALF_END) begin
          spi_cs_n_d = 1'b1;
          spi_sclk_d = 1'b1;
        end else if (!half_cnt[0]) begin
          spi_sclk_d = 1'b0;
          spi_mosi_d = tx_sr[15];
          tx_sr_d    = {tx_sr[14:0], 1'b0};
        end else begin
          spi_sclk_d = 1'b1;
          rx_sr_d    = {rx_sr[6:0], spi_miso};
        end
      end else begin
        div_cnt_d = div_cnt + DIV_W'(1);
      end
    end

    case (state)
      S_INIT_XFER: begin
        if (spi_cs_n) begin
          start_c = 1'b1;
          word_c  = INIT_WORD;
        end else if (done_c) begin
          init_done_d = 1'b1;
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        if (tick_c && gap_ok_c) begin
          start_c = 1'b1;
          word_c  = X_WORD;
          state_d = S_READ_X;
        end
      end
      S_READ_X: begin
        if (done_c) begin
          x_hold_d = rx_sr;
          state_d  = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_ok_c) begin
          start_c = 1'b1;
          word_c  = Y_WORD;
          state_d = S_READ_Y;
        end
      end
      S_READ_Y: begin
        if (done_c) state_d = S_UPDATE;
      end
      S_UPDATE: begin
        accel_data_x_d = x_hold;
        accel_data_y_d = rx_sr;
        data_valid_d   = 1'b1;
        state_d        = S_WAIT;
      end
      default: state_d = S_INIT_XFER;
    endcase

    if (start_c) begin
      spi_cs_n_d = 1'b0;
      spi_sclk_d = 1'b1;
      div_cnt_d  = '0;
      half_cnt_d = '0;
      tx_sr_d    = word_c;
      spi_mosi_d = word_c[15];
    end
  end

endmodule

// File: tb/tb_accel_spi_reader.sv
// Scoreboard bench for accel_spi_reader: two instances (fast-tick stress and CLK_DIV=3)
// driven by a mode-3 slave model; expected X/Y pairs are queued per read and popped on data_valid.
`timescale 1ns/1ps
module tb_accel_spi_reader;

  localparam int NI = 2;

  logic pixel_clk = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 pixel_clk = ~pixel_clk;

  task automatic chk(input string name, input bit ok, input int act, input int exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < NI; g++) begin : g_inst
    localparam int D   = (g == 0) ? 2 : 3;
    localparam int P   = (g == 0) ? 50 : 400;
    localparam int LAT = 68 * D + 2;

    logic       rst   = 1'b1;
    logic       rst_q = 1'b0;
    logic       miso  = 1'b0;
    logic       sclk, cs_n, mosi, dv, idone;
    logic [7:0] ax, ay;
    bit         done  = 1'b0;

    accel_spi_reader #(
      .CLK_DIV      (D),
      .SAMPLE_PERIOD(P),
      .INIT_ADDR    (8'h20),
      .INIT_DATA    (8'h77),
      .X_ADDR       (8'h29),
      .Y_ADDR       (8'h2B)
    ) u_dut (
      .pixel_clk   (pixel_clk),
      .rst         (rst),
      .spi_sclk    (sclk),
      .spi_cs_n    (cs_n),
      .spi_mosi    (mosi),
      .spi_miso    (miso),
      .accel_data_x(ax),
      .accel_data_y(ay),
      .data_valid  (dv),
      .init_done   (idone)
    );

    always @(posedge pixel_clk) rst_q <= rst;

    // Observer / slave model state; s counts clock edges since the last reset edge
    bit          started = 1'b0;
    bit          in_win  = 1'b0;
    int          s = 0, win_idx = 0, rises = 0, ph = 0, win_start = 0;
    int          last_rise_s = 0, last_dv_s = -1, n_dv = 0, xn = 0, yn = 0;
    logic        prev_sclk = 1'b1, prev_cs = 1'b1, prev_mosi = 1'b0, prev_dv = 1'b0;
    logic [15:0] mword = '0;
    logic [15:0] exp_word;
    logic [15:0] e;
    logic [7:0]  cur_data = '0, x_val = '0, y_val = '0, hx = '0, hy = '0;
    logic [15:0] exp_q [$];

    always @(negedge pixel_clk) begin
      if (rst_q) begin
        started = 1'b1; in_win = 1'b0; s = 0; win_idx = 0; last_dv_s = -1;
        hx = '0; hy = '0; miso = 1'b0;
        exp_q.delete();
        chk("rst_sclk",  sclk  == 1'b1, int'(sclk),  1);
        chk("rst_cs_n",  cs_n  == 1'b1, int'(cs_n),  1);
        chk("rst_mosi",  mosi  == 1'b0, int'(mosi),  0);
        chk("rst_x",     ax    == 8'h00, int'(ax),   0);
        chk("rst_y",     ay    == 8'h00, int'(ay),   0);
        chk("rst_dv",    dv    == 1'b0, int'(dv),    0);
        chk("rst_idone", idone == 1'b0, int'(idone), 0);
      end else if (started) begin
        s++;
        if (prev_cs && !cs_n) begin
          if (win_idx == 0)
            chk("init_start", s == 1, s, 1);
          else if (win_idx % 2 == 1) begin
            chk("x_start_on_tick", s % P == 0, s % P, 0);
            chk("cs_gap_min", s - last_rise_s >= 2 * D, s - last_rise_s, 2 * D);
          end else
            chk("gap_len", s - last_rise_s == 2 * D, s - last_rise_s, 2 * D);
          in_win = 1'b1; win_start = s; rises = 0; ph = 0; mword = '0; miso = 1'b0;
        end else if (!prev_cs && cs_n) begin
          in_win = 1'b0;
          exp_word = (win_idx == 0) ? 16'h2077 : ((win_idx % 2 == 1) ? 16'hA900 : 16'hAB00);
          chk("rises_per_window", rises == 16, rises, 16);
          chk("cs_low_len", s - win_start == 33 * D, s - win_start, 33 * D);
          chk("mosi_word", mword == exp_word, int'(mword), int'(exp_word));
          if (win_idx > 0 && win_idx % 2 == 0) exp_q.push_back({x_val, y_val});
          win_idx++;
          last_rise_s = s;
        end else if (in_win) begin
          ph++;
          if (sclk != prev_sclk) begin
            chk("sclk_phase", ph == D, ph, D);
            ph = 0;
            if (sclk) begin
              chk("mosi_stable_on_rise", mosi == prev_mosi, int'(mosi), int'(prev_mosi));
              rises++;
              mword = {mword[14:0], mosi};
              if (rises == 8) begin
                if (mword[7:0] == 8'hA9) begin
                  x_val = (xn == 0) ? 8'h5A : (xn == 1) ? 8'h80 : 8'($urandom_range(255));
                  xn++;
                  cur_data = x_val;
                end else if (mword[7:0] == 8'hAB) begin
                  y_val = (yn == 0) ? 8'hA5 : (yn == 1) ? 8'h7F : 8'($urandom_range(255));
                  yn++;
                  cur_data = y_val;
                end else
                  cur_data = 8'h00;
              end
            end else begin
              miso = (rises >= 8 && rises < 16) ? cur_data[15 - rises] : 1'b0;
            end
          end
        end

        if (cs_n) chk("sclk_idle_high", sclk == 1'b1, int'(sclk), 1);
        chk("init_done", idone == (win_idx > 0), int'(idone), int'(win_idx > 0));

        if (dv) begin
          n_dv++;
          chk("dv_width", !prev_dv, int'(prev_dv), 0);
          chk("dv_latency", s >= LAT - 1 && (s - (LAT - 1)) % P == 0, s, LAT - 1);
          if (last_dv_s >= 0)
            chk("dv_spacing", (s - last_dv_s) >= P && (s - last_dv_s) % P == 0, s - last_dv_s, P);
          last_dv_s = s;
          chk("dv_expected", exp_q.size() > 0, exp_q.size(), 1);
          if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            hx = e[15:8];
            hy = e[7:0];
          end
          chk("data_x", ax == hx, int'(ax), int'(hx));
          chk("data_y", ay == hy, int'(ay), int'(hy));
        end else begin
          chk("hold_x", ax == hx, int'(ax), int'(hx));
          chk("hold_y", ay == hy, int'(ay), int'(hy));
        end
      end
      prev_sclk = sclk; prev_cs = cs_n; prev_mosi = mosi; prev_dv = dv;
    end

    // Per-instance stimulus: reset, run reads; instance 0 also resets mid READ_Y
    initial begin
      int tgt;
      rst = 1'b1;
      repeat (3) @(negedge pixel_clk);
      rst = 1'b0;
      tgt = (g == 0) ? 4 : 8;
      for (int k = 0; k < 30000 && n_dv < tgt; k++) @(negedge pixel_clk);
      chk("dv_count", n_dv >= tgt, n_dv, tgt);
      if (g == 0) begin
        for (int k = 0; k < 5000 && !(in_win && win_idx > 0 && win_idx % 2 == 0 && rises == 9); k++)
          @(negedge pixel_clk);
        chk("found_read_y_bit10", in_win && win_idx % 2 == 0 && rises == 9, rises, 9);
        rst = 1'b1;
        @(negedge pixel_clk);
        rst = 1'b0;
        tgt = n_dv + 4;
        for (int k = 0; k < 30000 && n_dv < tgt; k++) @(negedge pixel_clk);
        chk("dv_count_after_reset", n_dv >= tgt, n_dv, tgt);
      end
      repeat (5) @(negedge pixel_clk);
      done = 1'b1;
    end
  end

  initial begin
    for (int k = 0; k < 80000 && !(g_inst[0].done && g_inst[1].done); k++) @(negedge pixel_clk);
    chk("run_complete", g_inst[0].done && g_inst[1].done,
        int'(g_inst[0].done) + int'(g_inst[1].done), 2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
